div_seq_unit: RTL

Multicycle signed 32-bit divider. It consumes the operand pair (A_out/B_out) that the divm special handler stages, and returns quotient and remainder in HI/LO registers for the multicycle datapath. The control unit pulses DivStart, stalls while DivBusy is high, and advances on DivDone. Semantics are MIPS DIV: quotient truncates toward zero; the remainder takes the sign of the dividend.

---
 rtl/div_seq_unit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/div_seq_unit.sv
// Multicycle signed divider with MIPS DIV semantics: quotient truncates toward zero,
// remainder follows the dividend's sign. One restoring step per cycle, then a sign-fix cycle.
module div_seq_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             DivStart,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             DivBusy,
  output logic             DivDone,
  output logic             DivZero
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;

  // Magnitudes are unsigned, so |most-negative| = 2^(WIDTH-1) fits in WIDTH bits.
  assign a_mag = A[WIDTH-1] ? -A : A;
  assign b_mag = B[WIDTH-1] ? -B : B;

  // The stored remainder is always below the divisor, so it fits in WIDTH bits;
  // only the shifted trial value needs the extra bit.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign rem_ge    = rem_shift >= {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    zero_d  = zero_q;

    unique case (state_q)
      StIdle: begin
        if (DivStart) begin
          if (B == '0) begin
            zero_d = 1'b1;
            done_d = 1'b1;
          end else begin
            neg_q_d = A[WIDTH-1] ^ B[WIDTH-1];
            neg_r_d = A[WIDTH-1];
            quo_d   = a_mag;
            dvs_d   = b_mag;
            rem_d   = '0;
            cnt_d   = CNT_W'(WIDTH);
            busy_d  = 1'b1;
            zero_d  = 1'b0;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d = rem_ge ? WIDTH'(rem_shift - {1'b0, dvs_q}) : rem_shift[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], rem_ge};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        lo_d    = neg_q_q ? -quo_q : quo_q;
        hi_d    = neg_r_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
    end
  end

  assign HI      = hi_q;
  assign LO      = lo_q;
  assign DivBusy = busy_q;
  assign DivDone = done_q;
  assign DivZero = zero_q;

endmodule
